// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if
// Handshake bundle between the issuing stage and the sequential ALU.
//   Issue side : in_valid / in_ready, func, a, b, acc_clr
//   Result side: out_valid / out_ready, result, ovf
//   Status     : acc (current accumulator value)
// Modports:
//   master - the core side (drives operands, consumes results)
//   slave  - the ALU side
// ---------------------------------------------------------------------------
interface alu_seq_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   func;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic         ovf;
  logic [N-1:0] acc;

  modport master (
    output in_valid, func, a, b, acc_clr, out_ready,
    input  in_ready, out_valid, result, ovf, acc
  );

  modport slave (
    input  in_valid, func, a, b, acc_clr, out_ready,
    output in_ready, out_valid, result, ovf, acc
  );
endinterface

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Multi-cycle signed fixed-point ALU: RI (pass immediate), ADD, MUL, and MAC
// into an internal accumulator. MUL/MAC use an N-step shift-add multiplier on
// operand magnitudes; the sign is applied after the last step. Results are
// optionally saturated (SAT=1) or wrapped (SAT=0); ovf flags overflow either way.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous, active-high reset
//   bus    - alu_seq_if.slave: issue handshake, result handshake, acc status
// Parameters:
//   N      - data width (two's complement), N >= 4
//   FRAC   - fractional bits; MUL keeps product[FRAC+N-1:FRAC]
//   SAT    - 1: clamp overflow to +max/-min, 0: truncate
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int N    = 8,
  parameter int FRAC = N - 1,
  parameter bit SAT  = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  alu_seq_if.slave  bus
);

  localparam int PW = 2 * N;
  localparam int CW = $clog2(N);
  localparam logic [N-1:0] MAX_V = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_V = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {
    F_RI  = 2'b00,
    F_ADD = 2'b01,
    F_MUL = 2'b10,
    F_MAC = 2'b11
  } func_t;

  // Signed add with overflow detection; returns {ovf, result}.
  function automatic logic [N:0] sat_add(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N:0] s;
    logic       o;
    s = {x[N-1], x} + {y[N-1], y};
    o = s[N] ^ s[N-1];
    if (o && SAT) return {1'b1, (s[N] ? MIN_V : MAX_V)};
    return {o, s[N-1:0]};
  endfunction

  // |x| as an unsigned N-bit value; -2^(N-1) maps to 2^(N-1), which still fits.
  function automatic logic [N-1:0] mag(input logic [N-1:0] x);
    return x[N-1] ? (~x + N'(1)) : x;
  endfunction

  // Apply the sign to the unsigned magnitude product, then slice/saturate.
  // Returns {ovf, result}. The product is out of range when its bits above
  // the kept slice are not a pure sign extension.
  function automatic logic [N:0] mul_finish(input logic [PW-1:0] mag_prod, input logic neg);
    logic [PW-1:0]        p;
    logic [PW-FRAC-N:0]   hi;
    logic                 o;
    p  = neg ? (~mag_prod + PW'(1)) : mag_prod;
    hi = p[PW-1:FRAC+N-1];
    o  = !((&hi) || !(|hi));
    if (o && SAT) return {1'b1, (p[PW-1] ? MIN_V : MAX_V)};
    return {o, p[FRAC+N-1:FRAC]};
  endfunction

  state_t         state_q, state_d;
  logic           is_mac_q, is_mac_d;
  logic           sign_q, sign_d;
  logic [N-1:0]   amag_q, amag_d;
  logic [PW-1:0]  prod_q, prod_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   result_q, result_d;
  logic           ovf_q, ovf_d;
  logic [N-1:0]   acc_q, acc_d;

  // One shift-add step: the high half absorbs |a| when the multiplier LSB
  // (living in the low half) is set, then the whole register shifts right.
  logic [N:0]     step_sum;
  logic [PW-1:0]  prod_step;
  logic [N-1:0]   mul_res, mac_sum;
  logic           mul_ovf, mac_ovf;

  assign step_sum  = {1'b0, prod_q[PW-1:N]} + {1'b0, (prod_q[0] ? amag_q : '0)};
  assign prod_step = {step_sum, prod_q[N-1:1]};
  assign {mul_ovf, mul_res} = mul_finish(prod_step, sign_q);
  assign {mac_ovf, mac_sum} = sat_add(acc_q, mul_res);

  always_comb begin
    // NOTE: every next-state value defaults to its register so no path through
    // the case statement leaves a variable unassigned (which would infer a latch).
    state_d  = state_q;
    is_mac_d = is_mac_q;
    sign_d   = sign_q;
    amag_d   = amag_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    acc_d    = acc_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Clearing here means a MAC started with acc_clr accumulates from 0.
          if (bus.acc_clr) acc_d = '0;
          case (func_t'(bus.func))
            F_RI: begin
              result_d = bus.b;
              ovf_d    = 1'b0;
              state_d  = DONE;
            end
            F_ADD: begin
              {ovf_d, result_d} = sat_add(bus.a, bus.b);
              state_d = DONE;
            end
            default: begin
              amag_d   = mag(bus.a);
              prod_d   = {{N{1'b0}}, mag(bus.b)};
              sign_d   = bus.a[N-1] ^ bus.b[N-1];
              is_mac_d = bus.func[0];
              cnt_d    = '0;
              state_d  = BUSY;
            end
          endcase
        end
      end

      BUSY: begin
        prod_d = prod_step;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          if (is_mac_q) begin
            result_d = mac_sum;
            ovf_d    = mul_ovf | mac_ovf;
            acc_d    = mac_sum;
          end else begin
            result_d = mul_res;
            ovf_d    = mul_ovf;
          end
        end
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      is_mac_q <= 1'b0;
      sign_q   <= 1'b0;
      amag_q   <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      is_mac_q <= is_mac_d;
      sign_q   <= sign_d;
      amag_q   <= amag_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      acc_q    <= acc_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;
  assign bus.acc       = acc_q;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Drives identical operations into a saturating (SAT=1) and a wrapping (SAT=0)
// instance of alu_seq. Expected results come from an integer arithmetic model
// and are queued at issue time, then popped when out_valid rises.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_seq;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, acc_clr, out_ready;
  logic [1:0] func;
  logic [7:0] a, b;

  always #5 clk = ~clk;

  alu_seq_if #(.N(N)) ifs ();
  alu_seq_if #(.N(N)) ifw ();

  assign ifs.in_valid  = in_valid;
  assign ifs.func      = func;
  assign ifs.a         = a;
  assign ifs.b         = b;
  assign ifs.acc_clr   = acc_clr;
  assign ifs.out_ready = out_ready;
  assign ifw.in_valid  = in_valid;
  assign ifw.func      = func;
  assign ifw.a         = a;
  assign ifw.b         = b;
  assign ifw.acc_clr   = acc_clr;
  assign ifw.out_ready = out_ready;

  alu_seq #(.N(N), .FRAC(7), .SAT(1'b1)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (ifs.slave)
  );

  alu_seq #(.N(N), .FRAC(7), .SAT(1'b0)) dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (ifw.slave)
  );

  typedef struct {
    logic [7:0] res_s;
    logic       ovf_s;
    logic [7:0] acc_s;
    logic [7:0] res_w;
    logic       ovf_w;
    logic [7:0] acc_w;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   acc_m_s, acc_m_w;
  int   tests_run, fails;

  // ---------------- reference model (integer arithmetic) ----------------
  function automatic int wrap8(input int v);
    logic signed [7:0] t;
    t = v[7:0];
    return int'(t);
  endfunction

  function automatic void add_model(input int x, input int y, input bit sat,
                                    output int r, output bit o);
    int s;
    s = x + y;
    o = (s > 127) || (s < -128);
    if (o && sat) r = (s > 0) ? 127 : -128;
    else          r = wrap8(s);
  endfunction

  function automatic void mul_model(input int x, input int y, input bit sat,
                                    output int r, output bit o);
    int p, q;
    p = x * y;
    q = p >>> 7;
    o = (q > 127) || (q < -128);
    if (o && sat) r = (q > 0) ? 127 : -128;
    else          r = wrap8(q);
  endfunction

  function automatic void model_op(input logic [1:0] f, input logic [7:0] av,
                                   input logic [7:0] bv, input bit clr, input bit sat,
                                   inout int accm, output int r, output bit o);
    int x, y, m, ar;
    bit mo, ao;
    x = int'($signed(av));
    y = int'($signed(bv));
    if (clr) accm = 0;
    case (f)
      2'b00: begin r = y; o = 1'b0; end
      2'b01: add_model(x, y, sat, r, o);
      2'b10: mul_model(x, y, sat, r, o);
      default: begin
        mul_model(x, y, sat, m, mo);
        add_model(accm, m, sat, ar, ao);
        accm = ar;
        r    = ar;
        o    = mo | ao;
      end
    endcase
  endfunction

  // ---------------- issue one op, check result, handshake ----------------
  task automatic run_op(input logic [1:0] f, input logic [7:0] av, input logic [7:0] bv,
                        input logic clr, input int hold);
    exp_t e;
    int   r, lat;
    bit   o;
    model_op(f, av, bv, clr, 1'b1, acc_m_s, r, o);
    e.res_s = 8'(r); e.ovf_s = o; e.acc_s = 8'(acc_m_s);
    model_op(f, av, bv, clr, 1'b0, acc_m_w, r, o);
    e.res_w = 8'(r); e.ovf_w = o; e.acc_w = 8'(acc_m_w);
    e.lat   = f[1] ? (N + 1) : 1;
    sb.push_back(e);

    tests_run++;
    if (ifs.in_ready !== 1'b1 || ifw.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL accept_ready: in_ready sat=%b wrap=%b, expected 1", ifs.in_ready, ifw.in_ready);
    end

    in_valid = 1'b1; func = f; a = av; b = bv; acc_clr = clr;
    @(posedge clk); #1;
    in_valid = 1'b0; acc_clr = 1'b0;
    lat = 1;
    while (ifs.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end

    e = sb.pop_front();
    tests_run++;
    if (lat != e.lat) begin
      fails++;
      $display("FAIL latency func=%0d: got %0d cycles, expected %0d", f, lat, e.lat);
    end
    tests_run++;
    if (ifw.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL wrap_valid func=%0d: out_valid=%b, expected 1", f, ifw.out_valid);
    end
    tests_run++;
    if (ifs.result !== e.res_s || ifs.ovf !== e.ovf_s) begin
      fails++;
      $display("FAIL sat_result func=%0d a=%h b=%h: got %h ovf=%b, expected %h ovf=%b",
               f, av, bv, ifs.result, ifs.ovf, e.res_s, e.ovf_s);
    end
    tests_run++;
    if (ifw.result !== e.res_w || ifw.ovf !== e.ovf_w) begin
      fails++;
      $display("FAIL wrap_result func=%0d a=%h b=%h: got %h ovf=%b, expected %h ovf=%b",
               f, av, bv, ifw.result, ifw.ovf, e.res_w, e.ovf_w);
    end

    // Hold the result with out_ready low; stray in_valid pulses must be ignored.
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0]; acc_clr = 1'b1; func = ~f; a = ~av; b = bv + 8'd1;
      @(posedge clk); #1;
      tests_run++;
      if (ifs.out_valid !== 1'b1 || ifs.in_ready !== 1'b0 || ifs.result !== e.res_s ||
          ifs.ovf !== e.ovf_s || ifw.result !== e.res_w || ifw.ovf !== e.ovf_w) begin
        fails++;
        $display("FAIL hold cycle %0d: valid=%b ready=%b res=%h/%h ovf=%b/%b, expected 1 0 %h/%h %b/%b",
                 i, ifs.out_valid, ifs.in_ready, ifs.result, ifw.result, ifs.ovf, ifw.ovf,
                 e.res_s, e.res_w, e.ovf_s, e.ovf_w);
      end
    end
    in_valid = 1'b0; acc_clr = 1'b0;

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++;
    if (ifs.out_valid !== 1'b0 || ifs.in_ready !== 1'b1 || ifw.out_valid !== 1'b0 ||
        ifw.in_ready !== 1'b1 || ifs.acc !== e.acc_s || ifw.acc !== e.acc_w) begin
      fails++;
      $display("FAIL post_handshake func=%0d: valid=%b/%b ready=%b/%b acc=%h/%h, expected 0/0 1/1 acc=%h/%h",
               f, ifs.out_valid, ifw.out_valid, ifs.in_ready, ifw.in_ready,
               ifs.acc, ifw.acc, e.acc_s, e.acc_w);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
    func = 2'b00; a = '0; b = '0;
    acc_m_s = 0; acc_m_w = 0;
    #12;
    tests_run++;
    if (ifs.in_ready !== 1'b1 || ifs.out_valid !== 1'b0 || ifs.result !== 8'h00 ||
        ifs.ovf !== 1'b0 || ifs.acc !== 8'h00 || ifw.in_ready !== 1'b1 ||
        ifw.out_valid !== 1'b0 || ifw.acc !== 8'h00) begin
      fails++;
      $display("FAIL reset_state: ready=%b valid=%b res=%h ovf=%b acc=%h, expected 1 0 00 0 00",
               ifs.in_ready, ifs.out_valid, ifs.result, ifs.ovf, ifs.acc);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    run_op(2'b01, 8'h05, 8'h03, 1'b0, 0);
  endtask

  task automatic test_add_overflow();
    run_op(2'b01, 8'h7F, 8'h01, 1'b0, 0);
    run_op(2'b01, 8'h80, 8'hFF, 1'b0, 0);
    run_op(2'b01, 8'hC0, 8'h30, 1'b0, 0);
  endtask

  task automatic test_mul();
    run_op(2'b10, 8'h40, 8'h40, 1'b0, 0);
    run_op(2'b10, 8'hC0, 8'h40, 1'b0, 0);
    run_op(2'b10, 8'h80, 8'h80, 1'b0, 0);
    run_op(2'b10, 8'h80, 8'h7F, 1'b0, 0);
  endtask

  task automatic test_mac();
    run_op(2'b11, 8'h40, 8'h40, 1'b1, 0);
    run_op(2'b11, 8'h40, 8'h40, 1'b0, 0);
    run_op(2'b00, 8'h00, 8'h11, 1'b1, 0);
    // Saturating accumulation chain
    run_op(2'b11, 8'h7F, 8'h7F, 1'b1, 0);
    run_op(2'b11, 8'h7F, 8'h7F, 1'b0, 0);
    run_op(2'b11, 8'h80, 8'h7F, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    run_op(2'b01, 8'h12, 8'h34, 1'b0, 5);
    run_op(2'b11, 8'h60, 8'hA0, 1'b0, 5);
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      run_op(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_async_reset();
    run_op(2'b11, 8'h40, 8'h40, 1'b1, 0);
    in_valid = 1'b1; func = 2'b10; a = 8'h40; b = 8'h40; acc_clr = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    tests_run++;
    if (ifs.out_valid !== 1'b0 || ifs.in_ready !== 1'b0 || ifs.acc !== 8'h20) begin
      fails++;
      $display("FAIL busy_before_reset: valid=%b ready=%b acc=%h, expected 0 0 20",
               ifs.out_valid, ifs.in_ready, ifs.acc);
    end
    #3 reset = 1'b1;
    #1;
    tests_run++;
    if (ifs.out_valid !== 1'b0 || ifs.acc !== 8'h00 || ifs.in_ready !== 1'b1 ||
        ifw.out_valid !== 1'b0 || ifw.acc !== 8'h00 || ifw.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL async_reset: valid=%b/%b acc=%h/%h ready=%b/%b, expected 0/0 00/00 1/1",
               ifs.out_valid, ifw.out_valid, ifs.acc, ifw.acc, ifs.in_ready, ifw.in_ready);
    end
    acc_m_s = 0; acc_m_w = 0;
    #1 reset = 1'b0;
    @(posedge clk); #1;
    run_op(2'b01, 8'h05, 8'h03, 1'b0, 0);
    run_op(2'b11, 8'hC0, 8'h40, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    run_op(2'b00, 8'h00, 8'h5A, 1'b0, 0);
    run_op(2'b10, 8'hE0, 8'hE0, 1'b0, 0);
    run_op(2'b01, 8'h81, 8'h81, 1'b0, 0);
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    test_reset();
    test_add_overflow();
    test_mul();
    test_mac();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
